fxu_rs: RTL and testbench



---
 rtl/fxu_pkg.sv | 18 +
 rtl/fxu_rs_pick.sv | 26 ++
 rtl/fxu_rs.sv | 113 +++++++++++
 tb/tb_fxu_rs.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fxu_pkg.sv
// fxu_pkg: FXU opcodes, widths and the reservation-station entry layout
package fxu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd4;
  localparam logic [3:0] OP_MOVL = 4'd5;
  localparam logic [3:0] OP_MOVH = 4'd6;
  localparam int IDX_W = 4;
  localparam int DATA_W = 16;
  typedef struct packed {
    logic [3:0] opcode;
    logic va_rdy;
    logic [DATA_W-1:0] va;
    logic vb_rdy;
    logic [DATA_W-1:0] vb;
    logic [7:0] i;
  } entry_t;
endpackage

// File: rtl/fxu_rs_pick.sv
// fxu_rs_pick: one-hot grant among req (lowest index, or oldest via older[j][k]=j older than k when AGE) plus found flag
module fxu_rs_pick #(
  parameter int N = 4,
  parameter bit AGE = 1'b0
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0] gnt,
  output logic found
);
  assign found = |req;
  if (AGE) begin : g_age
    always_comb begin
      gnt = '0;
      for (int k = 0; k < N; k++) begin
        gnt[k] = req[k];
        for (int j = 0; j < N; j++)
          if (j != k && req[j] && older[j][k]) gnt[k] = 1'b0;
      end
    end
  end else begin : g_low
    logic unused_older;
    assign unused_older = ^older;
    assign gnt = req & (~req + N'(1));
  end
endmodule

// File: rtl/fxu_rs.sv
// fxu_rs: FXU reservation station (clk, rst_n sync low, flush; dispatch in_*/in_ready; CDB wakeup cdb_*; registered issue out_*); FXU_RS_AGE_EN selects oldest-first issue
module fxu_rs
  import fxu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDXW = IDX_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [3:0] in_opcode,
  input  logic [IDXW-1:0] in_index,
  input  logic in_va_rdy,
  input  logic [15:0] in_va,
  input  logic in_vb_rdy,
  input  logic [15:0] in_vb,
  input  logic [7:0] in_i,
  input  logic cdb_valid,
  input  logic [IDXW-1:0] cdb_rob_index,
  input  logic [15:0] cdb_value,
  output logic out_valid,
  output logic [3:0] out_opcode,
  output logic [IDXW-1:0] out_index,
  output logic [15:0] out_va,
  output logic [15:0] out_vb,
  output logic [7:0] out_i
);
  entry_t ent [DEPTH];
  logic [IDXW-1:0] idx [DEPTH];
  logic [DEPTH-1:0] v, rdy, fgnt, sgnt;
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic ffound, sfound, disp, a_hit, b_hit;
  entry_t sel_e, new_e;
  logic [IDXW-1:0] sel_idx;
`ifdef FXU_RS_AGE_EN
  localparam bit AGE = 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) older <= '0;
    else if (disp)
      for (int k = 0; k < DEPTH; k++)
        if (fgnt[k])
          for (int j = 0; j < DEPTH; j++) begin
            older[j][k] <= v[j];
            older[k][j] <= 1'b0;
          end
  end
`else
  localparam bit AGE = 1'b0;
  assign older = '0;
`endif
  fxu_rs_pick #(.N(DEPTH), .AGE(1'b0)) u_free (.req(~v), .older('0), .gnt(fgnt), .found(ffound));
  fxu_rs_pick #(.N(DEPTH), .AGE(AGE)) u_sel (.req(rdy), .older(older), .gnt(sgnt), .found(sfound));
  assign in_ready = ffound;
  assign disp = in_valid && in_ready;
  assign a_hit = !in_va_rdy && cdb_valid && cdb_rob_index == in_va[IDXW-1:0];
  assign b_hit = !in_vb_rdy && cdb_valid && cdb_rob_index == in_vb[IDXW-1:0];
  assign new_e = '{opcode: in_opcode, va_rdy: in_va_rdy || a_hit, va: a_hit ? cdb_value : in_va,
                   vb_rdy: in_vb_rdy || b_hit, vb: b_hit ? cdb_value : in_vb, i: in_i};
  always_comb begin
    rdy = '0;
    for (int k = 0; k < DEPTH; k++) rdy[k] = v[k] && ent[k].va_rdy && ent[k].vb_rdy;
  end
  always_comb begin
    sel_e = '0;
    sel_idx = '0;
    for (int k = 0; k < DEPTH; k++)
      if (sgnt[k]) begin
        sel_e = ent[k];
        sel_idx = idx[k];
      end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      out_valid <= 1'b0;
      out_opcode <= OP_ADD;
      out_index <= '0;
      out_va <= '0;
      out_vb <= '0;
      out_i <= '0;
    end else if (flush) begin
      v <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sfound;
      if (sfound) begin
        out_opcode <= sel_e.opcode;
        out_index <= sel_idx;
        out_va <= sel_e.va;
        out_vb <= sel_e.vb;
        out_i <= sel_e.i;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (v[k] && cdb_valid && !ent[k].va_rdy && ent[k].va[IDXW-1:0] == cdb_rob_index) begin
          ent[k].va <= cdb_value;
          ent[k].va_rdy <= 1'b1;
        end
        if (v[k] && cdb_valid && !ent[k].vb_rdy && ent[k].vb[IDXW-1:0] == cdb_rob_index) begin
          ent[k].vb <= cdb_value;
          ent[k].vb_rdy <= 1'b1;
        end
        if (sgnt[k]) v[k] <= 1'b0;
        if (disp && fgnt[k]) begin
          v[k] <= 1'b1;
          ent[k] <= new_e;
          idx[k] <= in_index;
        end
      end
    end
  end
endmodule

// File: tb/tb_fxu_rs.sv
// tb_fxu_rs: directed self-checking bench for fxu_rs
module tb_fxu_rs;
  logic clk = 1'b0, rst_n, flush, in_valid, in_ready, in_va_rdy, in_vb_rdy, cdb_valid, out_valid;
  logic [3:0] in_opcode, in_index, cdb_rob_index, out_opcode, out_index;
  logic [15:0] in_va, in_vb, cdb_value, out_va, out_vb;
  logic [7:0] in_i, out_i;
  int n_chk = 0, n_fail = 0;
  fxu_rs dut (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
              .in_opcode(in_opcode), .in_index(in_index), .in_va_rdy(in_va_rdy), .in_va(in_va),
              .in_vb_rdy(in_vb_rdy), .in_vb(in_vb), .in_i(in_i), .cdb_valid(cdb_valid),
              .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value), .out_valid(out_valid),
              .out_opcode(out_opcode), .out_index(out_index), .out_va(out_va), .out_vb(out_vb), .out_i(out_i));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic disp(input logic [3:0] op, input logic [3:0] ix, input logic ar, input logic [15:0] a,
                      input logic br, input logic [15:0] b, input logic [7:0] im);
    in_valid = 1'b1; in_opcode = op; in_index = ix;
    in_va_rdy = ar; in_va = a; in_vb_rdy = br; in_vb = b; in_i = im;
  endtask
  task automatic cdb(input logic [3:0] t, input logic [15:0] val);
    cdb_valid = 1'b1; cdb_rob_index = t; cdb_value = val;
  endtask
  task automatic idle();
    in_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_opcode = '0; in_index = '0; in_va_rdy = 1'b0;
    in_va = '0; in_vb_rdy = 1'b0; in_vb = '0; in_i = '0; cdb_valid = 1'b0; cdb_rob_index = '0; cdb_value = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_opcode", out_opcode, 0);
    chk("rst out_index", out_index, 0);
    chk("rst out_va", out_va, 0);
    chk("rst out_vb", out_vb, 0);
    chk("rst out_i", out_i, 0);
    chk("rst in_ready", in_ready, 1);
    disp(4'd0, 4'd3, 1, 16'd5, 1, 16'd7, 8'h21);
    step(); idle();
    chk("add early", out_valid, 0);
    step();
    chk("add valid", out_valid, 1);
    chk("add opcode", out_opcode, 0);
    chk("add index", out_index, 3);
    chk("add va", out_va, 5);
    chk("add vb", out_vb, 7);
    chk("add i", out_i, 8'h21);
    step();
    chk("add one shot", out_valid, 0);
    chk("add hold va", out_va, 5);
    disp(4'd1, 4'd2, 0, 16'd9, 1, 16'd1, 8'h00);
    step(); idle();
    chk("sub wait0", out_valid, 0);
    step();
    chk("sub wait1", out_valid, 0);
    step();
    chk("sub wait2", out_valid, 0);
    cdb(4'd9, 16'h0010);
    step(); idle();
    chk("sub wake edge", out_valid, 0);
    step();
    chk("sub valid", out_valid, 1);
    chk("sub opcode", out_opcode, 1);
    chk("sub index", out_index, 2);
    chk("sub va", out_va, 16'h0010);
    chk("sub vb", out_vb, 1);
    step();
    chk("sub one shot", out_valid, 0);
    disp(4'd4, 4'd7, 0, 16'd6, 1, 16'd0, 8'h00);
    cdb(4'd6, 16'hABCD);
    step(); idle();
    step();
    chk("cap valid", out_valid, 1);
    chk("cap index", out_index, 7);
    chk("cap opcode", out_opcode, 4);
    chk("cap va", out_va, 16'hABCD);
    step();
    for (int k = 0; k < 4; k++) begin
      disp(4'd0, 4'(8 + k), 0, 16'(10 + k), 1, 16'd2, 8'h00);
      step();
    end
    idle();
    chk("full in_ready", in_ready, 0);
    disp(4'd0, 4'd15, 1, 16'd1, 1, 16'd1, 8'h00);
    step(); idle();
    chk("full drop ready", in_ready, 0);
    chk("full drop issue", out_valid, 0);
    cdb(4'd12, 16'h1234);
    step(); idle();
    chk("full wake ready", in_ready, 0);
    chk("full wake issue", out_valid, 0);
    step();
    chk("full issue valid", out_valid, 1);
    chk("full issue index", out_index, 10);
    chk("full issue va", out_va, 16'h1234);
    chk("full freed ready", in_ready, 1);
    step();
    chk("full no dropped op", out_valid, 0);
    flush = 1'b1;
    disp(4'd0, 4'd14, 1, 16'd3, 1, 16'd3, 8'h00);
    step(); idle();
    chk("flush in_ready", in_ready, 1);
    chk("flush out_valid", out_valid, 0);
    cdb(4'd10, 16'h0001);
    step();
    chk("flush post0", out_valid, 0);
    cdb(4'd11, 16'h0002);
    step();
    chk("flush post1", out_valid, 0);
    cdb(4'd13, 16'h0003);
    step(); idle();
    chk("flush post2", out_valid, 0);
    step();
    chk("flush post3", out_valid, 0);
    disp(4'd0, 4'd1, 0, 16'd5, 1, 16'd0, 8'h00);
    step();
    disp(4'd0, 4'd2, 0, 16'd6, 1, 16'd0, 8'h00);
    step(); idle();
    cdb(4'd5, 16'h0055);
    step(); idle();
    step();
    chk("age A valid", out_valid, 1);
    chk("age A index", out_index, 1);
    disp(4'd0, 4'd3, 0, 16'd6, 1, 16'd0, 8'h00);
    step(); idle();
    chk("age C disp", out_valid, 0);
    cdb(4'd6, 16'h0066);
    step(); idle();
    chk("age wake", out_valid, 0);
    step();
    chk("age first valid", out_valid, 1);
`ifdef FXU_RS_AGE_EN
    chk("age first index", out_index, 2);
`else
    chk("age first index", out_index, 3);
`endif
    chk("age first va", out_va, 16'h0066);
    step();
    chk("age second valid", out_valid, 1);
`ifdef FXU_RS_AGE_EN
    chk("age second index", out_index, 3);
`else
    chk("age second index", out_index, 2);
`endif
    step();
    chk("age drained", out_valid, 0);
    chk("age in_ready", in_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
